aludec_queue: RTL and testbench

ALUDEC_QUEUE -- requirements
Module: aludec_queue

---
 rtl/aludec_queue.sv | 161 ++++++++++++++++
 tb/tb_aludec_queue.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/aludec_queue.sv
// ALU-control decoder followed by a small decoded-entry queue.
// Each accepted MIPS instruction is decoded to its EXE_*_OP code and stored
// with the raw word and an invalid flag. Control state is reset; the entry
// storage is not, and the head outputs are forced to zero while empty.
module aludec_queue #(
    parameter int CTRL_W = 8,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_alucontrol,
    output logic [31:0]       out_instr,
    output logic              out_invalid,
    output logic [CNT_W-1:0]  inv_count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH) + 1;

    // ALU operation codes
    localparam logic [7:0] AND_OP    = 8'h24, OR_OP    = 8'h25, XOR_OP   = 8'h26, NOR_OP   = 8'h27;
    localparam logic [7:0] ANDI_OP   = 8'h59, ORI_OP   = 8'h5A, XORI_OP  = 8'h5B, LUI_OP   = 8'h5C;
    localparam logic [7:0] SLL_OP    = 8'h7C, SLLV_OP  = 8'h04, SRL_OP   = 8'h02, SRLV_OP  = 8'h06;
    localparam logic [7:0] SRA_OP    = 8'h03, SRAV_OP  = 8'h07;
    localparam logic [7:0] MFHI_OP   = 8'h10, MTHI_OP  = 8'h11, MFLO_OP  = 8'h12, MTLO_OP  = 8'h13;
    localparam logic [7:0] SLT_OP    = 8'h2A, SLTU_OP  = 8'h2B, SLTI_OP  = 8'h57, SLTIU_OP = 8'h58;
    localparam logic [7:0] ADD_OP    = 8'h20, ADDU_OP  = 8'h21, SUB_OP   = 8'h22, SUBU_OP  = 8'h23;
    localparam logic [7:0] ADDI_OP   = 8'h55, ADDIU_OP = 8'h56;
    localparam logic [7:0] MULT_OP   = 8'h18, MULTU_OP = 8'h19, DIV_OP   = 8'h1A, DIVU_OP  = 8'h1B;
    localparam logic [7:0] J_OP      = 8'h4F, JAL_OP   = 8'h50, JALR_OP  = 8'h09, JR_OP    = 8'h08;
    localparam logic [7:0] BEQ_OP    = 8'h51, BNE_OP   = 8'h52, BLEZ_OP  = 8'h53, BGTZ_OP  = 8'h54;
    localparam logic [7:0] BLTZ_OP   = 8'h40, BGEZ_OP  = 8'h41, BLTZAL_OP = 8'h4A, BGEZAL_OP = 8'h4B;
    localparam logic [7:0] LB_OP     = 8'hE0, LH_OP    = 8'hE1, LW_OP    = 8'hE3, LBU_OP   = 8'hE4;
    localparam logic [7:0] LHU_OP    = 8'hE5, SB_OP    = 8'hE8, SH_OP    = 8'hE9, SW_OP    = 8'hEB;
    localparam logic [7:0] SYSCALL_OP = 8'h0C, BREAK_OP = 8'h0B;
    localparam logic [7:0] ERET_OP   = 8'h6B, MTC0_OP  = 8'h60, MFC0_OP  = 8'h5D;

    // Instruction word to ALU code; 0 marks a reserved instruction.
    function automatic logic [7:0] decode(input logic [31:0] w);
        logic [5:0] op;
        logic [5:0] funct;
        logic [4:0] rt;
        op     = w[31:26];
        funct  = w[5:0];
        rt     = w[20:16];
        decode = 8'h00;
        if (w == 32'h42000018) begin
            decode = ERET_OP;
        end else if (w[31:21] == 11'b01000000100) begin
            decode = MTC0_OP;
        end else if (w[31:21] == 11'b01000000000) begin
            decode = MFC0_OP;
        end else if (op == 6'h00) begin
            case (funct)
                6'h24: decode = AND_OP;   6'h25: decode = OR_OP;
                6'h26: decode = XOR_OP;   6'h27: decode = NOR_OP;
                6'h00: decode = SLL_OP;   6'h02: decode = SRL_OP;
                6'h03: decode = SRA_OP;   6'h04: decode = SLLV_OP;
                6'h06: decode = SRLV_OP;  6'h07: decode = SRAV_OP;
                6'h10: decode = MFHI_OP;  6'h11: decode = MTHI_OP;
                6'h12: decode = MFLO_OP;  6'h13: decode = MTLO_OP;
                6'h20: decode = ADD_OP;   6'h21: decode = ADDU_OP;
                6'h22: decode = SUB_OP;   6'h23: decode = SUBU_OP;
                6'h2A: decode = SLT_OP;   6'h2B: decode = SLTU_OP;
                6'h18: decode = MULT_OP;  6'h19: decode = MULTU_OP;
                6'h1A: decode = DIV_OP;   6'h1B: decode = DIVU_OP;
                6'h08: decode = JR_OP;    6'h09: decode = JALR_OP;
                6'h0D: decode = BREAK_OP; 6'h0C: decode = SYSCALL_OP;
                default: decode = 8'h00;
            endcase
        end else if (op == 6'h01) begin
            case (rt)
                5'h00: decode = BLTZ_OP;   5'h01: decode = BGEZ_OP;
                5'h10: decode = BLTZAL_OP; 5'h11: decode = BGEZAL_OP;
                default: decode = 8'h00;
            endcase
        end else begin
            case (op)
                6'h0C: decode = ANDI_OP;  6'h0E: decode = XORI_OP;
                6'h0D: decode = ORI_OP;   6'h0F: decode = LUI_OP;
                6'h08: decode = ADDI_OP;  6'h09: decode = ADDIU_OP;
                6'h0A: decode = SLTI_OP;  6'h0B: decode = SLTIU_OP;
                6'h04: decode = BEQ_OP;   6'h05: decode = BNE_OP;
                6'h07: decode = BGTZ_OP;  6'h06: decode = BLEZ_OP;
                6'h02: decode = J_OP;     6'h03: decode = JAL_OP;
                6'h20: decode = LB_OP;    6'h24: decode = LBU_OP;
                6'h21: decode = LH_OP;    6'h25: decode = LHU_OP;
                6'h23: decode = LW_OP;    6'h28: decode = SB_OP;
                6'h29: decode = SH_OP;    6'h2B: decode = SW_OP;
                default: decode = 8'h00;
            endcase
        end
    endfunction

    // Counter increment that sticks at all ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [CTRL_W-1:0] mem_code  [DEPTH];
    logic [31:0]       mem_instr [DEPTH];
    logic              mem_inv   [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occ;

    logic [CTRL_W-1:0] in_code;
    logic              in_invalid;
    logic              push;
    logic              pop;

    assign in_code    = CTRL_W'(decode(instr));
    assign in_invalid = (in_code == '0);
    assign in_ready   = (occ < OCC_W'(DEPTH));
    assign out_valid  = (occ != '0);
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;

    assign out_alucontrol = out_valid ? mem_code[rd_ptr]  : '0;
    assign out_instr      = out_valid ? mem_instr[rd_ptr] : 32'h0;
    assign out_invalid    = out_valid ? mem_inv[rd_ptr]   : 1'b0;

    // Pointers, occupancy and invalid counter; flush overrides push and pop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            inv_count <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
            if (push && in_invalid) inv_count <= sat_inc(inv_count);
        end
    end

    // Entry storage written at the tail on each accepted, unflushed push.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_code[wr_ptr]  <= in_code;
            mem_instr[wr_ptr] <= instr;
            mem_inv[wr_ptr]   <= in_invalid;
        end
    end
endmodule

// File: tb/tb_aludec_queue.sv
// Directed bench for aludec_queue: reset, decode, full, invalid, flush,
// push/pop overlap and counter saturation (second instance with CNT_W=2).
module tb_aludec_queue;
    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid, flush, out_ready;
    logic [31:0] instr;
    logic        in_ready, out_valid, out_invalid;
    logic [7:0]  out_alucontrol;
    logic [31:0] out_instr;
    logic [15:0] inv_count;

    logic        s_in_valid, s_out_ready;
    logic [31:0] s_instr;
    logic        s_in_ready, s_out_valid, s_out_invalid;
    logic [7:0]  s_out_alucontrol;
    logic [31:0] s_out_instr;
    logic [1:0]  s_inv_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] tbl_instr [8];
    logic [7:0]  tbl_code  [8];

    always #5 clk = ~clk;

    aludec_queue #(.CTRL_W(8), .DEPTH(2), .CNT_W(16)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_alucontrol(out_alucontrol), .out_instr(out_instr),
        .out_invalid(out_invalid), .inv_count(inv_count)
    );

    aludec_queue #(.CTRL_W(8), .DEPTH(2), .CNT_W(2)) dut_sat (
        .clk(clk), .resetn(resetn), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .instr(s_instr), .flush(1'b0), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_alucontrol(s_out_alucontrol), .out_instr(s_out_instr),
        .out_invalid(s_out_invalid), .inv_count(s_inv_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl_instr[0] = 32'h42000018; tbl_code[0] = 8'h6B; // eret
        tbl_instr[1] = 32'h40806000; tbl_code[1] = 8'h60; // mtc0
        tbl_instr[2] = 32'h40016000; tbl_code[2] = 8'h5D; // mfc0
        tbl_instr[3] = 32'h04110000; tbl_code[3] = 8'h4B; // bgezal
        tbl_instr[4] = 32'h0000000D; tbl_code[4] = 8'h0B; // break
        tbl_instr[5] = 32'h0000000C; tbl_code[5] = 8'h0C; // syscall
        tbl_instr[6] = 32'h0000000F; tbl_code[6] = 8'h00; // funct 0x0F unmapped
        tbl_instr[7] = 32'h3C010001; tbl_code[7] = 8'h5C; // lui

        resetn = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; instr = 32'h0;
        s_in_valid = 1'b0; s_out_ready = 1'b1; s_instr = 32'h0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_alucontrol", 32'(out_alucontrol), 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_invalid", 32'(out_invalid), 32'd0);
        chk("rst_inv_count", 32'(inv_count), 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;

        // Two entries queued, then asynchronous reset mid-cycle
        in_valid = 1'b1; instr = 32'hFC000000; step();
        instr = 32'h00851021; step();
        in_valid = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        chk("pre_rst_ready", 32'(in_ready), 32'd0);
        chk("pre_rst_inv", 32'(inv_count), 32'd1);
        chk("pre_rst_head", out_instr, 32'hFC000000);
        resetn = 1'b0;
        #2;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_inv", 32'(inv_count), 32'd0);
        chk("async_rst_ready", 32'(in_ready), 32'd1);
        chk("async_rst_instr", out_instr, 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;

        // addu decode with consumer ready
        in_valid = 1'b1; instr = 32'h00851021; out_ready = 1'b1; step();
        in_valid = 1'b0;
        chk("addu_valid", 32'(out_valid), 32'd1);
        chk("addu_code", 32'(out_alucontrol), 32'h21);
        chk("addu_invalid", 32'(out_invalid), 32'd0);
        chk("addu_instr", out_instr, 32'h00851021);
        step();
        chk("addu_empty", 32'(out_valid), 32'd0);
        chk("addu_empty_code", 32'(out_alucontrol), 32'd0);
        out_ready = 1'b0;

        // Fill to DEPTH, third push held off, one pop reopens
        in_valid = 1'b1; instr = 32'h34420001; step();
        instr = 32'h8C430004; step();
        chk("full_ready", 32'(in_ready), 32'd0);
        chk("full_head_ori", 32'(out_alucontrol), 32'h5A);
        instr = 32'h3C010001; step();
        chk("held_ready", 32'(in_ready), 32'd0);
        chk("held_head_stable", out_instr, 32'h34420001);
        chk("held_code_stable", 32'(out_alucontrol), 32'h5A);
        in_valid = 1'b0; out_ready = 1'b1; step();
        out_ready = 1'b0;
        chk("pop_ready", 32'(in_ready), 32'd1);
        chk("pop_head_lw", 32'(out_alucontrol), 32'hE3);
        chk("pop_head_instr", out_instr, 32'h8C430004);
        out_ready = 1'b1; step();
        out_ready = 1'b0;
        chk("drain_empty", 32'(out_valid), 32'd0);
        chk("no_held_accept_inv", 32'(inv_count), 32'd0);

        // Reserved instructions
        in_valid = 1'b1; instr = 32'hFC000000; step();
        instr = 32'h04A50000; step();
        in_valid = 1'b0;
        chk("inv_count_2", 32'(inv_count), 32'd2);
        chk("inv1_code", 32'(out_alucontrol), 32'd0);
        chk("inv1_flag", 32'(out_invalid), 32'd1);
        chk("inv1_instr", out_instr, 32'hFC000000);
        out_ready = 1'b1; step();
        chk("inv2_code", 32'(out_alucontrol), 32'd0);
        chk("inv2_flag", 32'(out_invalid), 32'd1);
        chk("inv2_instr", out_instr, 32'h04A50000);
        step();
        out_ready = 1'b0;
        chk("inv_drained", 32'(out_valid), 32'd0);

        // Flush a full queue while presenting input
        in_valid = 1'b1; instr = 32'h8C430004; step();
        instr = 32'h34420001; step();
        chk("pre_flush_full", 32'(in_ready), 32'd0);
        instr = 32'hFC000000; flush = 1'b1; step();
        chk("flush_empty", 32'(out_valid), 32'd0);
        chk("flush_ready", 32'(in_ready), 32'd1);
        chk("flush_inv", 32'(inv_count), 32'd2);
        // Flush beats an acceptable invalid push
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_push_dropped", 32'(out_valid), 32'd0);
        chk("flush_push_inv", 32'(inv_count), 32'd2);

        // Simultaneous push and pop with one entry held
        in_valid = 1'b1; instr = 32'h00851021; step();
        instr = 32'h34420001; out_ready = 1'b1; step();
        in_valid = 1'b0;
        chk("pushpop_valid", 32'(out_valid), 32'd1);
        chk("pushpop_ready", 32'(in_ready), 32'd1);
        chk("pushpop_head", 32'(out_alucontrol), 32'h5A);
        step();
        out_ready = 1'b0;
        chk("pushpop_empty", 32'(out_valid), 32'd0);

        // Decode table including coprocessor priority cases
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; instr = tbl_instr[i]; step();
            in_valid = 1'b0;
            chk($sformatf("tbl%0d_code", i), 32'(out_alucontrol), 32'(tbl_code[i]));
            chk($sformatf("tbl%0d_flag", i), 32'(out_invalid), (tbl_code[i] == 8'h00) ? 32'd1 : 32'd0);
            out_ready = 1'b1; step();
            out_ready = 1'b0;
        end
        chk("tbl_inv_count", 32'(inv_count), 32'd3);

        // Saturating counter on the CNT_W=2 instance
        s_in_valid = 1'b1; s_instr = 32'hFC000000;
        step(); step();
        chk("sat_count_2", 32'(s_inv_count), 32'd2);
        step(); step(); step();
        s_in_valid = 1'b0;
        chk("sat_count_3", 32'(s_inv_count), 32'd3);
        chk("sat_ready", 32'(s_in_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
